// File: rtl/fifo_arb_pkg.sv
// Shared types, helpers and default parameters for the FIFO write-port arbiter.
//   lock_state_e : lock FSM states (ARB, LOCK)
//   cred_w()     : bit width needed to hold values 0..n
//   DEF_*        : default parameter values
// Optional feature macro used by the arbiter: FIFO_ARB_LOCK_EN.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_BURST_MAX  = 4;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } lock_state_e;

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cred_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_req  : request vector
//   i_ptr  : index of the last winner; search starts at i_ptr+1
//   i_mask : requests outside the mask are ignored (used to force an owner)
//   o_gnt  : one-hot grant, zero when no masked request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic [NUM_REQ-1:0]         i_mask,
  output logic [NUM_REQ-1:0]         o_gnt
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_req_m;
  logic [PW-1:0]      w_idx;
  logic               w_found;

  assign w_req_m = i_req & i_mask;

  // Walk the ring starting just after the pointer; first masked request wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = PW'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && w_req_m[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with credit-based occupancy tracking so a full FIFO is never written.
// Optional burst lock (owner keeps the port for up to BURST_MAX grants) is
// built only when FIFO_ARB_LOCK_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-producer write request, held with data until granted
//   req_data    : producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_lock    : burst ownership request (lock build only)
//   gnt         : combinational one-hot grant
//   fifo_winc   : registered write strobe
//   fifo_wdata  : registered write data
//   fifo_rd     : accepted FIFO read, returns one credit
//   credits     : free FIFO slots as seen by the arbiter
//   cred_err    : sticky credit over-return flag
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_winc,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_rd,
  output logic [cred_w(DEPTH)-1:0]      credits,
  output logic                          cred_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = cred_w(DEPTH);

  logic [PW-1:0]         r_rr_ptr;
  logic [CW-1:0]         r_credits;
  logic                  r_winc;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cred_err;

  logic [NUM_REQ-1:0]    w_mask;
  logic [NUM_REQ-1:0]    w_pick;
  logic                  w_grant;
  logic [PW-1:0]         w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [CW-1:0]         w_credits_nxt;
  logic                  w_lock_exit;
  logic [PW-1:0]         w_lock_owner;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req  (req),
    .i_ptr  (r_rr_ptr),
    .i_mask (w_mask),
    .o_gnt  (w_pick)
  );

  // No grant without a free slot, and none while reset is held.
  assign gnt     = (r_credits != '0 && !rst) ? w_pick : '0;
  assign w_grant = |gnt;

  // Encode the winner and select its word.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_gnt_idx  = PW'(i);
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A grant and a returned credit in the same cycle cancel out.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_grant && !fifo_rd) begin
      w_credits_nxt = r_credits - CW'(1);
    end else if (!w_grant && fifo_rd && r_credits != CW'(DEPTH)) begin
      w_credits_nxt = r_credits + CW'(1);
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  localparam int unsigned BW = cred_w(BURST_MAX);

  lock_state_e   r_state;
  lock_state_e   w_state_nxt;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] w_owner_nxt;
  logic [BW-1:0] r_burst;
  logic [BW-1:0] w_burst_nxt;

  // While locked only the owner may be picked; depends on registered state only.
  assign w_mask       = (r_state == LOCK) ? (NUM_REQ'(1) << r_owner) : '1;
  assign w_lock_owner = r_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
      r_owner <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst;
    w_lock_exit = 1'b0;
    case (r_state)
      ARB: begin
        if (w_grant && req_lock[w_gnt_idx] && BURST_MAX > 1) begin
          w_state_nxt = LOCK;
          w_owner_nxt = w_gnt_idx;
          w_burst_nxt = BW'(1);
        end
      end
      LOCK: begin
        if (w_grant) begin
          w_burst_nxt = r_burst + BW'(1);
        end
        if (!req_lock[r_owner] ||
            (w_grant && (r_burst + BW'(1)) == BW'(BURST_MAX))) begin
          w_state_nxt = ARB;
          w_burst_nxt = '0;
          w_lock_exit = 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end
`else
  logic w_unused;

  assign w_mask       = '1;
  assign w_lock_exit  = 1'b0;
  assign w_lock_owner = '0;
  assign w_unused     = ^{req_lock, 32'(BURST_MAX)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= PW'(NUM_REQ - 1);
      r_credits  <= CW'(DEPTH);
      r_winc     <= 1'b0;
      r_wdata    <= '0;
      r_cred_err <= 1'b0;
    end else begin
      r_winc    <= w_grant;
      r_credits <= w_credits_nxt;
      if (w_grant) begin
        r_wdata  <= w_sel_data;
        r_rr_ptr <= w_gnt_idx;
      end else if (w_lock_exit) begin
        r_rr_ptr <= w_lock_owner;
      end
      if (fifo_rd && r_credits == CW'(DEPTH)) begin
        r_cred_err <= 1'b1;
      end
    end
  end

  assign fifo_winc  = r_winc;
  assign fifo_wdata = r_wdata;
  assign credits    = r_credits;
  assign cred_err   = r_cred_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=4, DEPTH=8).
// Expected write words are queued when a grant is expected and checked
// against fifo_winc/fifo_wdata one cycle later. Lock scenarios run only
// when FIFO_ARB_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  gnt;
  logic        fifo_winc;
  logic [3:0]  fifo_wdata;
  logic        fifo_rd;
  logic [3:0]  credits;
  logic        cred_err;

  int          n_err    = 0;
  int          n_checks = 0;
  int          n_winc   = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(4), .DEPTH(8), .BURST_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .gnt        (gnt),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .fifo_rd    (fifo_rd),
    .credits    (credits),
    .cred_err   (cred_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a grant to producer k this cycle and queue its word.
  task automatic exp_gnt(input string tag, input int k);
    logic [3:0] w;
    logic [3:0] one;
    #1;
    one = 4'b0001 << k;
    chk(tag, 32'(gnt), 32'(one));
    w = req_data[k*4 +: 4];
    exp_q.push_back(w);
  endtask

  // Scoreboard: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_winc === 1'b1) begin
      n_winc++;
      if (exp_q.size() == 0) chk("winc_unexpected", 32'(fifo_winc), 32'(0));
      else chk("wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; req = '0; req_lock = '0; fifo_rd = 1'b0;
    req_data = {4'h8, 4'h7, 4'h6, 4'h5};
    tick(); tick();
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_winc", 32'(fifo_winc), 32'(0));
    chk("rst_wdata", 32'(fifo_wdata), 32'(0));
    chk("rst_credits", 32'(credits), 32'(8));
    chk("rst_cred_err", 32'(cred_err), 32'(0));
    rst = 1'b0;
    tick();

    // Round-robin drain of all eight credits.
    req = 4'b1111;
    for (int n = 0; n < 11; n++) begin
      chk("rr_credits", 32'(credits), 32'((n < 8) ? 8 - n : 0));
      if (n < 8) exp_gnt("rr_gnt", n % 4);
      else begin #1; chk("rr_gnt_full", 32'(gnt), 32'(0)); end
      tick();
    end
    req = '0;
    tick();
    chk("rr_winc_count", 32'(n_winc), 32'(8));

    // Credit return while starved, then simultaneous grant + read.
    req = 4'b0100; req_data[11:8] = 4'h3; fifo_rd = 1'b1;
    #1; chk("cr_gnt_starved", 32'(gnt), 32'(0));
    tick();
    fifo_rd = 1'b0;
    chk("cr_credits_1", 32'(credits), 32'(1));
    exp_gnt("cr_gnt2", 2);
    tick();
    chk("cr_credits_0", 32'(credits), 32'(0));
    req = '0; fifo_rd = 1'b1;
    tick();
    chk("cr_credits_back", 32'(credits), 32'(1));
    req = 4'b0100;
    exp_gnt("cr_both_gnt", 2);
    tick();
    chk("cr_both_credits", 32'(credits), 32'(1));
    req = '0; fifo_rd = 1'b0;
    tick();

    // Data path: word appears exactly one cycle after its grant.
    req = 4'b0010; req_data[7:4] = 4'hA;
    exp_gnt("dp_gnt1", 1);
    tick();
    req = '0;
    chk("dp_winc", 32'(fifo_winc), 32'(1));
    chk("dp_wdata", 32'(fifo_wdata), 32'hA);
    tick();
    chk("dp_winc_off", 32'(fifo_winc), 32'(0));
    chk("dp_wdata_hold", 32'(fifo_wdata), 32'hA);
    fifo_rd = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    fifo_rd = 1'b0;
    chk("dp_refill", 32'(credits), 32'(8));
    chk("dp_no_err", 32'(cred_err), 32'(0));

    // Over-return saturates and sets a sticky error.
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("ov_credits", 32'(credits), 32'(8));
    chk("ov_err", 32'(cred_err), 32'(1));
    tick(); tick();
    chk("ov_err_sticky", 32'(cred_err), 32'(1));

    // Reset while a write is in flight.
    req = 4'b1111;
    exp_gnt("mr_gnt", 2);
    tick();
    rst = 1'b1;
    #1; chk("mr_gnt_in_rst", 32'(gnt), 32'(0));
    tick();
    chk("mr_winc_drop", 32'(fifo_winc), 32'(0));
    chk("mr_credits", 32'(credits), 32'(8));
    chk("mr_err_clr", 32'(cred_err), 32'(0));
    rst = 1'b0;
    exp_gnt("mr_first_p0", 0);
    tick();
    req = '0;
    tick();

`ifdef FIFO_ARB_LOCK_EN
    // Full burst: owner held for BURST_MAX grants, then round-robin resumes.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; req_lock = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      exp_gnt("lk_burst", 0);
      tick();
    end
    exp_gnt("lk_after_burst", 1);
    tick();
    req = '0; req_lock = '0;
    tick();

    // Lock released after two grants.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; req_lock = 4'b0001;
    exp_gnt("lk_drop_g1", 0);
    tick();
    req_lock = 4'b0000;
    exp_gnt("lk_drop_g2", 0);
    tick();
    exp_gnt("lk_drop_next", 1);
    tick();
    req = '0;
    tick();
`endif

    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
